gray_updown_counter: RTL and testbench
======================================

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the counter width in bits; the legal range is 2..8.
REQ-002 Port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-003 Port Rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 Port En, input, 1 bit: count enable; when high, advances the count by one step.
REQ-005 Port Up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 Port Sat, input, 1 bit: limit mode; 1 = saturate at the end values, 0 = wrap around.
REQ-007 Port Load, input, 1 bit: synchronous load strobe.
REQ-008 Port LoadGray, input, WIDTH bits: Gray-coded load value.
REQ-009 Port GrayOut, output, WIDTH bits: registered Gray-coded count.
REQ-010 Port BinOut, output, WIDTH bits: binary equivalent of GrayOut, valid in the same cycle.
REQ-011 Port Wrap, output, 1 bit: one-cycle pulse marking a wrap-around.
REQ-012 Port AtMax and port AtMin, outputs, 1 bit each: high while the count equals binary 2^WIDTH-1 and 0 respectively.

Function
REQ-013 The count SHALL be held in one WIDTH-bit state register; GrayOut SHALL be that register's Gray encoding, or the register itself.
REQ-014 BinOut SHALL be derived as b[MSB] = g[MSB] and b[i] = b[i+1] XOR g[i].
REQ-015 Gray encoding SHALL follow g = b XOR (b >> 1).
REQ-016 Per edge, the block SHALL apply exactly one action, in this priority order: Rst, then Load, then En, then hold.
REQ-017 On Load, the count SHALL take the value of LoadGray on the next edge, without conversion loss.
REQ-018 On Load, Wrap SHALL stay 0 and En SHALL be ignored that cycle.
REQ-019 With En=1 and Up=1, the binary count SHALL increment by 1 modulo 2^WIDTH.
REQ-020 With En=1 and Up=0, the binary count SHALL decrement by 1 modulo 2^WIDTH.
REQ-021 Latency SHALL be one cycle: inputs sampled at edge N appear on GrayOut, BinOut and Wrap after edge N.
REQ-022 With Sat=0, an increment from max SHALL go to 0 and a decrement from 0 SHALL go to max.
REQ-023 In either wrap case, Wrap SHALL be high for exactly the following cycle.
REQ-024 With Sat=1, an increment at max or a decrement at 0 SHALL hold the count and keep Wrap at 0.
REQ-025 Every En-driven change of GrayOut SHALL flip exactly one bit, including the wrap steps (Gray max = 1 followed by zeros, to 0).
REQ-026 Wrap SHALL be 0 in every cycle that does not follow a wrap step, including hold cycles and load cycles.
REQ-027 AtMax and AtMin SHALL be decoded from the current register state with no added latency.
REQ-028 AtMax and AtMin SHALL never be high together for WIDTH >= 1.
REQ-029 Changes to Up or Sat with En=0 SHALL have no effect on state.
REQ-030 Changes to Up or Sat SHALL take effect on the next enabled edge.
REQ-031 Outputs SHALL be glitch-free registered values, except BinOut, AtMax and AtMin, which are combinational decodes of the register only and never of the inputs.

Reset
REQ-032 On the edge where Rst=1, the count SHALL become 0, so GrayOut = 0, BinOut = 0, Wrap = 0, AtMin = 1 and AtMax = 0.
REQ-033 Rst SHALL override simultaneous Load and En.
REQ-034 Rst asserted mid-count SHALL abandon the step in progress.
REQ-035 Rst asserted in the cycle after a wrap SHALL clear Wrap on that edge.
REQ-036 After Rst deasserts, counting SHALL resume on the first edge with En=1.

Verification (WIDTH=5)
REQ-037 Rst then En=1, Up=1, Sat=0 for 32 cycles -> GrayOut follows 00000, 00001, 00011, 00010, ..., 10000, then 00000; Wrap is high only in the cycle after 10000 to 00000; each step has a Hamming distance of 1.
REQ-038 Load with LoadGray=00000 and Up=0, Sat=0, En=1 for one cycle -> GrayOut=10000, BinOut=11111, Wrap=1, AtMax=1.
REQ-039 Sat=1 at BinOut=31 with Up=1, En=1 for 3 cycles -> GrayOut holds 10000 and Wrap stays 0.
REQ-040 Sat=1 at BinOut=0 with Up=0, En=1 -> GrayOut holds 00000 and AtMin stays 1.
REQ-041 Load=1 with LoadGray=01101 and En=1 in the same cycle -> GrayOut=01101 and BinOut=01001 (9); the count does not step.
REQ-042 Rst=1 together with Load=1 and En=1 while BinOut=17 -> next cycle GrayOut=00000 and Wrap=0.
REQ-043 All cycles -> BinOut equals the Gray-to-binary conversion of GrayOut.

Source files
------------

// File: rtl/gray_updown_counter.sv
// Gray-coded up/down counter with load, saturate/wrap limit mode and a
// one-cycle wrap pulse. The Gray code is the stored state, so GrayOut comes
// straight from a flop. BinOut, AtMax and AtMin are decoded from that flop.
module gray_updown_counter #(
   parameter int WIDTH = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             Up,
   input  logic             Sat,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadGray,
   output logic [WIDTH-1:0] GrayOut,
   output logic [WIDTH-1:0] BinOut,
   output logic             Wrap,
   output logic             AtMax,
   output logic             AtMin
);

   localparam logic [WIDTH-1:0] MAX_BIN = '1;
   localparam logic [WIDTH-1:0] MIN_BIN = '0;
   localparam logic [WIDTH-1:0] ONE_BIN = WIDTH'(1);

   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] gray_d;
   logic             wrap_q;
   logic             wrap_d;
   logic [WIDTH-1:0] bin_cur;
   logic [WIDTH-1:0] bin_step;

   // Gray-to-binary decode of the stored state, MSB first.
   always_comb begin
      bin_cur = '0;
      bin_cur[WIDTH-1] = gray_q[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin_cur[i] = bin_cur[i+1] ^ gray_q[i];
      end
   end

   // Pick the next state. Load wins over En and never raises Wrap. A counting
   // step runs in binary and is re-encoded to Gray, so it flips exactly one bit.
   always_comb begin
      gray_d   = gray_q;
      wrap_d   = 1'b0;
      bin_step = bin_cur;
      if (Load) begin
         gray_d = LoadGray;
      end else if (En) begin
         if (Up) begin
            if (bin_cur == MAX_BIN) begin
               if (!Sat) begin
                  bin_step = MIN_BIN;
                  wrap_d   = 1'b1;
               end
            end else begin
               bin_step = bin_cur + ONE_BIN;
            end
         end else begin
            if (bin_cur == MIN_BIN) begin
               if (!Sat) begin
                  bin_step = MAX_BIN;
                  wrap_d   = 1'b1;
               end
            end else begin
               bin_step = bin_cur - ONE_BIN;
            end
         end
         gray_d = bin_step ^ (bin_step >> 1);
      end
   end

   // State register. Reset overrides load and count, and clears a pending wrap pulse.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   // Output decodes depend only on the register, never on the inputs.
   always_comb begin
      GrayOut = gray_q;
      BinOut  = bin_cur;
      Wrap    = wrap_q;
      AtMax   = (bin_cur == MAX_BIN);
      AtMin   = (bin_cur == MIN_BIN);
   end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter at WIDTH=5. Stimulus pushes the
// hand-computed expected binary count and wrap flag. A monitor pops one entry
// after every edge and compares all outputs against it.
module tb_gray_updown_counter;

   localparam int W = 5;

   typedef struct {
      logic [W-1:0] bin;
      logic         wrap;
      logic         step;
      string        name;
   } exp_t;

   logic         clock = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         sat = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] loadGray = '0;
   logic [W-1:0] grayOut;
   logic [W-1:0] binOut;
   logic         wrapOut;
   logic         atMax;
   logic         atMin;

   exp_t         expQueue[$];
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] prevGray = '0;

   gray_updown_counter #(.WIDTH(W)) dut (
      .Clk(clock),
      .Rst(rst),
      .En(en),
      .Up(up),
      .Sat(sat),
      .Load(load),
      .LoadGray(loadGray),
      .GrayOut(grayOut),
      .BinOut(binOut),
      .Wrap(wrapOut),
      .AtMax(atMax),
      .AtMin(atMin)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
   task automatic applyStimulus(input logic r, input logic l, input logic [W-1:0] lg,
                                input logic e, input logic u, input logic s,
                                input logic [W-1:0] expBin, input logic expWrap,
                                input logic isStep, input string name);
      exp_t item;
      @(negedge clock);
      rst = r; load = l; loadGray = lg; en = e; up = u; sat = s;
      item.bin = expBin; item.wrap = expWrap; item.step = isStep; item.name = name;
      expQueue.push_back(item);
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   // Monitor: after each rising edge, compare the DUT outputs with the oldest queued expectation.
   initial begin
      exp_t e;
      logic [W-1:0] expGray;
      forever begin
         @(posedge clock);
         #1;
         if (expQueue.size() > 0) begin
            e = expQueue.pop_front();
            expGray = e.bin ^ (e.bin >> 1);
            checkOutput({e.name, ".gray"}, grayOut, expGray);
            checkOutput({e.name, ".bin"}, binOut, e.bin);
            checkOutput({e.name, ".wrap"}, W'(wrapOut), W'(e.wrap));
            checkOutput({e.name, ".atMax"}, W'(atMax), W'(e.bin == 5'd31));
            checkOutput({e.name, ".atMin"}, W'(atMin), W'(e.bin == 5'd0));
            if (e.step) begin
               checkOutput({e.name, ".hamming"}, W'($countones(grayOut ^ prevGray)), W'(1));
            end
         end
         prevGray = grayOut;
      end
   end

   // Directed sequence.
   initial begin
      int budget;
      applyStimulus(1, 0, 5'b00000, 0, 1, 0, 5'd0, 0, 0, "reset");
      for (int i = 1; i <= 32; i++) begin
         applyStimulus(0, 0, 5'b00000, 1, 1, 0, W'(i % 32), (i == 32), 1, $sformatf("up%0d", i));
      end
      applyStimulus(0, 1, 5'b00000, 1, 0, 0, 5'd0, 0, 0, "load0");
      applyStimulus(0, 0, 5'b00000, 1, 0, 0, 5'd31, 1, 1, "decWrap");
      applyStimulus(0, 0, 5'b00000, 0, 1, 1, 5'd31, 0, 0, "holdUpSat");
      applyStimulus(0, 0, 5'b00000, 0, 0, 0, 5'd31, 0, 0, "holdDn");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 5'b00000, 1, 1, 1, 5'd31, 0, 0, $sformatf("satMax%0d", i));
      end
      applyStimulus(0, 0, 5'b00000, 1, 1, 0, 5'd0, 1, 1, "upWrap");
      applyStimulus(1, 0, 5'b00000, 1, 1, 0, 5'd0, 0, 0, "rstAfterWrap");
      applyStimulus(0, 0, 5'b00000, 1, 0, 1, 5'd0, 0, 0, "satMin0");
      applyStimulus(0, 0, 5'b00000, 1, 0, 1, 5'd0, 0, 0, "satMin1");
      applyStimulus(0, 1, 5'b01101, 1, 1, 0, 5'd9, 0, 0, "load9");
      applyStimulus(0, 0, 5'b00000, 1, 0, 0, 5'd8, 0, 1, "dn8");
      applyStimulus(0, 0, 5'b00000, 1, 1, 0, 5'd9, 0, 1, "up9");
      applyStimulus(0, 0, 5'b00000, 1, 1, 0, 5'd10, 0, 1, "up10");
      applyStimulus(0, 1, 5'b11001, 0, 1, 0, 5'd17, 0, 0, "load17");
      applyStimulus(1, 1, 5'b01101, 1, 1, 0, 5'd0, 0, 0, "rstLoadEn");
      applyStimulus(0, 0, 5'b00000, 1, 1, 0, 5'd1, 0, 1, "resume1");
      applyStimulus(0, 1, 5'b11000, 0, 0, 0, 5'd16, 0, 0, "load16");
      applyStimulus(0, 0, 5'b00000, 1, 0, 1, 5'd15, 0, 1, "dn15");
      applyStimulus(0, 0, 5'b00000, 0, 1, 0, 5'd15, 0, 0, "hold15");
      budget = 10;
      while (expQueue.size() > 0 && budget > 0) begin
         @(posedge clock);
         budget--;
      end
      #2;
      if (expQueue.size() > 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQueue.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation still running, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
